icache_dm: RTL

ICACHE_DM -- requirements
Module: icache_dm

---
 rtl/icache_dm_pkg.sv | 14 +
 rtl/icache_dm_array.sv | 54 +++++
 rtl/icache_dm.sv | 123 ++++++++++++
 3 files changed

// File: rtl/icache_dm_pkg.sv
// rtl/icache_dm_pkg.sv - shared constants and FSM encoding for the direct-mapped instruction cache
package icache_dm_pkg;

  localparam int          DEF_INDEX_BITS = 4;
  localparam int          DEF_WORD_BITS  = 2;
  localparam logic [31:0] NOP            = 32'h0000_0013;

  // Two-bit encoding leaves spare codes that the FSM folds back to idle.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_REFILL = 2'b01
  } state_t;

endpackage

// File: rtl/icache_dm_array.sv
// rtl/icache_dm_array.sv - tag/valid/data storage with one write port and combinational read
module icache_dm_array #(
  parameter int INDEX_BITS = 4,
  parameter int WORD_BITS  = 2,
  parameter int TAG_BITS   = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_all,
  input  logic                  data_we,
  input  logic                  line_we,
  input  logic [INDEX_BITS-1:0] w_index,
  input  logic [WORD_BITS-1:0]  w_word,
  input  logic [31:0]           w_data,
  input  logic [TAG_BITS-1:0]   w_tag,
  input  logic [INDEX_BITS-1:0] r_index,
  input  logic [WORD_BITS-1:0]  r_word,
  output logic                  r_valid,
  output logic [TAG_BITS-1:0]   r_tag,
  output logic [31:0]           r_data
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << WORD_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES*WORDS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (clr_all) begin
      valid_q <= '0;
    end else if (line_we) begin
      valid_q[w_index] <= 1'b1;
    end
  end

  // Tag and data contents are never reset; the valid bits alone gate hits.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[w_index] <= w_tag;
    end
    if (data_we) begin
      data_q[{w_index, w_word}] <= w_data;
    end
  end

  assign r_valid = valid_q[r_index];
  assign r_tag   = tag_q[r_index];
  assign r_data  = data_q[{r_index, r_word}];

endmodule

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped instruction cache with zero-latency hit and word-serial refill
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int WORD_BITS  = DEF_WORD_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        req,
  output logic [31:0] data,
  output logic        valid,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int LINE_LSB = WORD_BITS + 2;
  localparam int TAG_LSB  = LINE_LSB + INDEX_BITS;
  localparam int TAG_BITS = 32 - TAG_LSB;

  state_t                state_q, state_d;
  logic [WORD_BITS-1:0]  cnt_q, cnt_d;
  logic [31:LINE_LSB]    base_q, base_d;

  logic [WORD_BITS-1:0]  a_off;
  logic [INDEX_BITS-1:0] a_idx;
  logic [TAG_BITS-1:0]   a_tag;
  logic                  r_valid;
  logic [TAG_BITS-1:0]   r_tag;
  logic [31:0]           r_data;
  logic                  hit;
  logic                  data_we, line_we, clr_all;
  logic                  unused_byte_bits;

  assign a_off = addr[LINE_LSB-1:2];
  assign a_idx = addr[TAG_LSB-1:LINE_LSB];
  assign a_tag = addr[31:TAG_LSB];
  assign unused_byte_bits = ^addr[1:0];

  icache_dm_array #(
    .INDEX_BITS(INDEX_BITS),
    .WORD_BITS (WORD_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .clr_all(clr_all),
    .data_we(data_we),
    .line_we(line_we),
    .w_index(base_q[TAG_LSB-1:LINE_LSB]),
    .w_word (cnt_q),
    .w_data (mem_rdata),
    .w_tag  (base_q[31:TAG_LSB]),
    .r_index(a_idx),
    .r_word (a_off),
    .r_valid(r_valid),
    .r_tag  (r_tag),
    .r_data (r_data)
  );

  // A flush cycle never reports a hit, even for a line still marked valid.
  assign hit   = (state_q == ST_IDLE) && req && !flush && r_valid && (r_tag == a_tag);
  assign valid = hit;
  assign data  = hit ? r_data : NOP;

  assign mem_req  = (state_q == ST_REFILL);
  assign mem_addr = mem_req ? {base_q, cnt_q, 2'b00} : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    data_we = 1'b0;
    line_we = 1'b0;
    clr_all = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          clr_all = 1'b1;
        end else if (req && !hit) begin
          state_d = ST_REFILL;
          cnt_d   = '0;
          base_d  = addr[31:LINE_LSB];
        end
      end
      ST_REFILL: begin
        if (flush) begin
          clr_all = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (mem_rvalid) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            line_we = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
